// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers and MTHI/MTLO writes.
// Optional divider enabled by defining MDU_DIV_EN; without it DIV/DIVU are no-ops.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  input  logic        HiLoSel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  localparam logic [CNT_W-1:0] MUL_CYC = CNT_W'(5);
`ifdef MDU_DIV_EN
  localparam logic [CNT_W-1:0] DIV_CYC = CNT_W'(10);
  localparam logic [2:0]       OP_DIV  = 3'd2;
  localparam logic [2:0]       OP_DIVU = 3'd3;
`endif
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic              uns_q, uns_d;
  logic              busy_q, busy_d;

  // Single signed 33x33 multiply covers both MULT and MULTU via the extension bit.
  logic signed [XLEN:0]   a_ext, b_ext;
  logic [2*XLEN-1:0]      prod;
  assign a_ext = $signed({~uns_q & a_q[XLEN-1], a_q});
  assign b_ext = $signed({~uns_q & b_q[XLEN-1], b_q});
  assign prod  = 64'(a_ext) * 64'(b_ext);

`ifdef MDU_DIV_EN
  // Divide magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. 0x80000000 / -1 falls out as LO=0x80000000, HI=0.
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs, q_abs, r_abs, quo, rem;
  assign a_neg = ~uns_q & a_q[XLEN-1];
  assign b_neg = ~uns_q & b_q[XLEN-1];
  assign a_abs = a_neg ? -a_q : a_q;
  assign b_abs = b_neg ? -b_q : b_q;
  assign q_abs = a_abs / b_abs;
  assign r_abs = a_abs % b_abs;
  assign quo   = (a_neg ^ b_neg) ? -q_abs : q_abs;
  assign rem   = a_neg ? -r_abs : r_abs;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    uns_d   = uns_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (MDOp)
            OP_MULT, OP_MULTU: begin
              state_d = S_MUL;
              cnt_d   = MUL_CYC;
              a_d     = SrcA;
              b_d     = SrcB;
              uns_d   = MDOp[0];
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              state_d = S_DIV;
              cnt_d   = DIV_CYC;
              a_d     = SrcA;
              b_d     = SrcB;
              uns_d   = MDOp[0];
            end
`endif
            OP_MTHI: hi_d = SrcA;
            OP_MTLO: lo_d = SrcA;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          {hi_d, lo_d} = prod;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (b_q != '0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      uns_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      uns_q   <= uns_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign Busy  = busy_q;
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign MDOut = HiLoSel ? hi_q : lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed and randomized operations against an arithmetic model.
// Divider expectations follow whether MDU_DIV_EN is defined for the build.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic [31:0] SrcA, SrcB;
  logic [2:0]  MDOp;
  logic        Start, HiLoSel;
  logic        Busy;
  logic [31:0] HI, LO, MDOut;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB), .MDOp(MDOp),
    .Start(Start), .HiLoSel(HiLoSel), .Busy(Busy), .HI(HI), .LO(LO), .MDOut(MDOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: new {HI,LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a, b,
                                          input logic [31:0] hi, lo);
    longint la, lb, q, r;
    logic [63:0] res;
    res = {hi, lo};
    case (op)
      3'd0: begin la = longint'($signed(a)); lb = longint'($signed(b)); res = 64'(la * lb); end
      3'd1: begin la = longint'({32'b0, a}); lb = longint'({32'b0, b}); res = 64'(la * lb); end
`ifdef MDU_DIV_EN
      3'd2, 3'd3: begin
        if (b != 32'd0) begin
          la = (op == 3'd2) ? longint'($signed(a)) : longint'({32'b0, a});
          lb = (op == 3'd2) ? longint'($signed(b)) : longint'({32'b0, b});
          q = la / lb;
          r = la % lb;
          res = {r[31:0], q[31:0]};
        end
      end
`endif
      3'd4: res = {a, lo};
      3'd5: res = {hi, a};
      default: ;
    endcase
    return res;
  endfunction

  function automatic int ref_cycles(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd1) return 5;
`ifdef MDU_DIV_EN
    if (op == 3'd2 || op == 3'd3) return 10;
`endif
    return 0;
  endfunction

  // Issue one op, scramble operands after acceptance, count Busy cycles,
  // optionally pulse an MTLO Start during Busy, and flag any early HI/LO change.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, input bit intrude,
                        output int cycles, output bit early);
    logic [31:0] pre_hi, pre_lo;
    @(negedge clk);
    pre_hi = HI; pre_lo = LO;
    Start = 1'b1; MDOp = op; SrcA = a; SrcB = b;
    @(negedge clk);
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom; MDOp = 3'($urandom);
    cycles = 0; early = 1'b0;
    while (Busy === 1'b1 && cycles < 40) begin
      cycles++;
      if (HI !== pre_hi || LO !== pre_lo) early = 1'b1;
      if (intrude && cycles == 2) begin
        Start = 1'b1; MDOp = 3'd5; SrcA = $urandom;
      end else begin
        Start = 1'b0;
      end
      @(negedge clk);
    end
    Start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_chk++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else n_pass++;
    n_chk++; if (HI !== 32'd0) $display("FAIL reset_hi: got %h want 0", HI); else n_pass++;
    n_chk++; if (LO !== 32'd0) $display("FAIL reset_lo: got %h want 0", LO); else n_pass++;
    n_chk++; if (MDOut !== 32'd0) $display("FAIL reset_mdout: got %h want 0", MDOut); else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult;
    int cyc; bit early;
    run_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, cyc, early);
    {m_hi, m_lo} = {32'hFFFFFFFF, 32'hFFFFFFFA};
    n_chk++; if (cyc != 5) $display("FAIL mult_busy_cycles: got %0d want 5", cyc); else n_pass++;
    n_chk++; if (early) $display("FAIL mult_early_write: HI/LO changed while Busy"); else n_pass++;
    n_chk++; if (HI !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h want ffffffff", HI); else n_pass++;
    n_chk++; if (LO !== 32'hFFFFFFFA) $display("FAIL mult_lo: got %h want fffffffa", LO); else n_pass++;
    HiLoSel = 1'b1; #1;
    n_chk++; if (MDOut !== 32'hFFFFFFFF) $display("FAIL mdout_hi: got %h want ffffffff", MDOut); else n_pass++;
    HiLoSel = 1'b0; #1;
    n_chk++; if (MDOut !== 32'hFFFFFFFA) $display("FAIL mdout_lo: got %h want fffffffa", MDOut); else n_pass++;
  endtask

  task automatic test_multu;
    int cyc; bit early;
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, cyc, early);
    {m_hi, m_lo} = {32'hFFFFFFFE, 32'h00000001};
    n_chk++; if (cyc != 5) $display("FAIL multu_busy_cycles: got %0d want 5", cyc); else n_pass++;
    n_chk++; if (early) $display("FAIL multu_early_write: HI/LO changed while Busy"); else n_pass++;
    n_chk++; if (HI !== 32'hFFFFFFFE) $display("FAIL multu_hi: got %h want fffffffe", HI); else n_pass++;
    n_chk++; if (LO !== 32'h00000001) $display("FAIL multu_lo: got %h want 00000001", LO); else n_pass++;
  endtask

  task automatic test_mthi_mtlo;
    int cyc; bit early;
    logic [31:0] v;
    v = $urandom;
    run_op(3'd4, v, $urandom, 1'b0, cyc, early);
    n_chk++; if (cyc != 0) $display("FAIL mthi_busy: got %0d want 0", cyc); else n_pass++;
    n_chk++; if (HI !== v) $display("FAIL mthi_hi: got %h want %h", HI, v); else n_pass++;
    n_chk++; if (LO !== m_lo) $display("FAIL mthi_lo_kept: got %h want %h", LO, m_lo); else n_pass++;
    m_hi = v;
    v = $urandom;
    run_op(3'd5, v, $urandom, 1'b0, cyc, early);
    n_chk++; if (cyc != 0) $display("FAIL mtlo_busy: got %0d want 0", cyc); else n_pass++;
    n_chk++; if (LO !== v) $display("FAIL mtlo_lo: got %h want %h", LO, v); else n_pass++;
    n_chk++; if (HI !== m_hi) $display("FAIL mtlo_hi_kept: got %h want %h", HI, m_hi); else n_pass++;
    m_lo = v;
  endtask

  task automatic test_reserved;
    int cyc; bit early;
    for (int k = 6; k < 8; k++) begin
      run_op(3'(k), $urandom, $urandom, 1'b0, cyc, early);
      n_chk++; if (cyc != 0) $display("FAIL reserved_busy op%0d: got %0d want 0", k, cyc); else n_pass++;
      n_chk++; if ({HI, LO} !== {m_hi, m_lo})
        $display("FAIL reserved_hilo op%0d: got %h_%h want %h_%h", k, HI, LO, m_hi, m_lo);
      else n_pass++;
    end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div;
    int cyc; bit early;
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, cyc, early);
    n_chk++; if (cyc != 10) $display("FAIL div_busy_cycles: got %0d want 10", cyc); else n_pass++;
    n_chk++; if (early) $display("FAIL div_early_write: HI/LO changed while Busy"); else n_pass++;
    n_chk++; if (LO !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h want fffffffd", LO); else n_pass++;
    n_chk++; if (HI !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h want ffffffff", HI); else n_pass++;
    {m_hi, m_lo} = {32'hFFFFFFFF, 32'hFFFFFFFD};
    run_op(3'd2, 32'd7, 32'd0, 1'b0, cyc, early);
    n_chk++; if (cyc != 10) $display("FAIL div0_busy_cycles: got %0d want 10", cyc); else n_pass++;
    n_chk++; if ({HI, LO} !== {m_hi, m_lo})
      $display("FAIL div0_hilo: got %h_%h want %h_%h", HI, LO, m_hi, m_lo);
    else n_pass++;
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, cyc, early);
    n_chk++; if ({HI, LO} !== {32'h0, 32'h80000000})
      $display("FAIL div_ovf: got %h_%h want 00000000_80000000", HI, LO);
    else n_pass++;
    run_op(3'd4, 32'h12345678, 32'd0, 1'b0, cyc, early);
    run_op(3'd3, 32'd100, 32'd7, 1'b1, cyc, early);
    n_chk++; if (cyc != 10) $display("FAIL divu_busy_cycles: got %0d want 10", cyc); else n_pass++;
    n_chk++; if (HI !== 32'd2) $display("FAIL divu_hi: got %h want 2", HI); else n_pass++;
    n_chk++; if (LO !== 32'd14) $display("FAIL divu_lo: got %h want 14", LO); else n_pass++;
    {m_hi, m_lo} = {32'd2, 32'd14};
  endtask
`else
  task automatic test_div;
    int cyc; bit early;
    run_op(3'd2, 32'd10, 32'd2, 1'b0, cyc, early);
    n_chk++; if (cyc != 0) $display("FAIL div_off_busy: got %0d want 0", cyc); else n_pass++;
    n_chk++; if ({HI, LO} !== {m_hi, m_lo})
      $display("FAIL div_off_hilo: got %h_%h want %h_%h", HI, LO, m_hi, m_lo);
    else n_pass++;
    run_op(3'd3, 32'd10, 32'd2, 1'b0, cyc, early);
    n_chk++; if (cyc != 0) $display("FAIL divu_off_busy: got %0d want 0", cyc); else n_pass++;
  endtask
`endif

  task automatic test_random;
    int cyc, exp_cyc; bit early;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      exp = ref_op(op, a, b, m_hi, m_lo);
      exp_cyc = ref_cycles(op);
      run_op(op, a, b, 1'($urandom_range(0, 1)), cyc, early);
      n_chk++; if (cyc != exp_cyc)
        $display("FAIL rand%0d_cycles op%0d: got %0d want %0d", i, op, cyc, exp_cyc);
      else n_pass++;
      n_chk++; if (early && exp_cyc != 0) $display("FAIL rand%0d_early op%0d", i, op); else n_pass++;
      n_chk++; if ({HI, LO} !== exp)
        $display("FAIL rand%0d_hilo op%0d a=%h b=%h: got %h_%h want %h", i, op, a, b, HI, LO, exp);
      else n_pass++;
      {m_hi, m_lo} = exp;
    end
  endtask

  task automatic test_reset_mid;
    int cyc; bit early;
    logic [31:0] v;
    run_op(3'd4, 32'hA5A5A5A5, 32'd0, 1'b0, cyc, early);
    run_op(3'd5, 32'h5A5A5A5A, 32'd0, 1'b0, cyc, early);
    @(negedge clk);
    Start = 1'b1; MDOp = 3'd0; SrcA = 32'd1234; SrcB = 32'd5678;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_chk++; if (Busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", Busy); else n_pass++;
    n_chk++; if ({HI, LO} !== 64'd0) $display("FAIL rstmid_hilo: got %h_%h want 0", HI, LO); else n_pass++;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    v = $urandom;
    reset = 1'b1;
    Start = 1'b1; MDOp = 3'd5; SrcA = v;
    @(posedge clk); #1;
    Start = 1'b0;
    n_chk++; if (LO !== v) $display("FAIL first_start_lo: got %h want %h", LO, v); else n_pass++;
    m_lo = v;
    repeat (8) @(negedge clk);
    n_chk++; if ({HI, LO} !== {m_hi, m_lo})
      $display("FAIL rstmid_no_late_write: got %h_%h want %h_%h", HI, LO, m_hi, m_lo);
    else n_pass++;
    n_chk++; if (Busy !== 1'b0) $display("FAIL rstmid_busy_after: got %b want 0", Busy); else n_pass++;
  endtask

  initial begin
    Start = 1'b0; MDOp = '0; SrcA = '0; SrcB = '0; HiLoSel = 1'b0;
    test_reset();
    test_mult();
    test_multu();
    test_mthi_mtlo();
    test_reserved();
    test_div();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
